snd_memreader: RTL and testbench
================================

Name: snd_memreader

Overview:
- Upstream stage of the sound output path. Fetches 32-bit sample words from DDR through an AXI4 read master and writes them into the write side of the sample FIFO.
- The I2S serial converter drains that FIFO on SND_BCLK.
- Decodes the same COMMAND/LOOP/DATASIZE control set as the converter, so fetch and playback start, pause and stop together.

Parameters:
- BURST_LEN, 16, maximum beats per AXI burst (1..256).
- FIFO_DEPTH, 1024, capacity of the sample FIFO in words.

Ports:
- ACLK  in  1  bus clock; all logic is on the rising edge.
- ARST  in  1  reset, asynchronous, active-high.
- COMMAND  in  2  01 = play/resume, 10 = pause, 11 = stop, 00 = no-op.
- LOOP  in  1  1 = restart from BASEADDR after the last word.
- BASEADDR  in  32  byte address of the first word; word aligned.
- DATASIZE  in  29  number of 32-bit words to fetch.
- FIFOWRCNT  in  11  FIFO write-side fill count.
- FIFOWR  out  1  FIFO write strobe.
- FIFODIN  out  32  FIFO write data.
- ARADDR  out  32  AXI read address.
- ARLEN  out  8  AXI burst length minus 1.
- ARVALID  out  1  AXI address valid.
- ARREADY  in  1  AXI address ready.
- RDATA  in  32  AXI read data.
- RRESP  in  2  AXI read response.
- RLAST  in  1  AXI last beat of burst.
- RVALID  in  1  AXI read data valid.
- RREADY  out  1  AXI read data ready.
- BUSY  out  1  1 whenever the state is not IDLE.
- RDERR  out  1  sticky read-error flag.

Behaviour:
- Reset values: all outputs 0; WORDCNT (29 bit) = 0; state = IDLE.
- Reset mid-burst drops ARVALID/RREADY immediately; the interconnect is reset by the same ARST.
- Fixed AXI fields (not ports): ARSIZE = 3'b010, ARBURST = INCR. Only one burst is outstanding at a time.

States:
- IDLE: on COMMAND==01 with DATASIZE!=0 -> SPACE; clear RDERR. With DATASIZE==0, stay IDLE; ARVALID never asserts.
- SPACE: let LEN = min(BURST_LEN, DATASIZE-WORDCNT).
  - COMMAND==11 -> IDLE, WORDCNT=0.
  - COMMAND==10 -> PAUSE.
  - Else if FIFO_DEPTH - FIFOWRCNT >= LEN -> ADDR, latching ARADDR = BASEADDR + (WORDCNT<<2) (mod 2^32) and ARLEN = LEN-1.
- ADDR: ARVALID=1, held with ARADDR/ARLEN stable until ARREADY; then -> DATA.
- DATA: RREADY=1 for the whole state.
  - Each RVALID beat: registered FIFOWR=1 and FIFODIN=RDATA on the next cycle (one-cycle latency); WORDCNT+1.
  - On RLAST beat -> SETTLE.
  - COMMAND 10/11 during DATA is latched as pending and acted on in SETTLE; the burst always completes.
- SETTLE: 2 cycles, so FIFOWRCNT reflects the last write. Then:
  - pending stop -> IDLE, WORDCNT=0.
  - pending pause -> PAUSE.
  - WORDCNT==DATASIZE and LOOP -> WORDCNT=0, SPACE.
  - WORDCNT==DATASIZE and !LOOP -> IDLE, WORDCNT=0.
  - otherwise -> SPACE.
- PAUSE: COMMAND==01 -> SPACE, keeping WORDCNT. COMMAND==11 -> IDLE, WORDCNT=0.

Error and boundary rules:
- RRESP!=00 on any beat sets RDERR. The data is still written, so FIFO word count stays aligned with the converter's DATACNT.
- RDERR clears only on ARST or an IDLE->SPACE start.
- RVALID outside DATA is ignored; RREADY=0 outside DATA.
- DATASIZE changing mid-play takes effect at the next LEN computation. If WORDCNT>DATASIZE, treat as end-of-data.
- BASEADDR must be aligned to BURST_LEN*4 when the optional feature is absent.

Optional Feature:
- Macro: SND_MEMRD_4K_EN.
- When defined: LEN = min(BURST_LEN, DATASIZE-WORDCNT, (4096 - ARADDR[11:0])>>2). No burst crosses a 4 KB boundary for any word-aligned BASEADDR.
- When undefined: the 4 KB term is omitted and no split logic is synthesised.

Test Plan:
- Reset then COMMAND=01, BASEADDR=0x1000_0000, DATASIZE=40, LOOP=0, FIFOWRCNT=0 -> bursts at 0x1000_0000/0x1000_0040/0x1000_0080 with ARLEN 15/15/7; 40 FIFOWR pulses carrying RDATA in order; then IDLE, BUSY=0.
- FIFOWRCNT=1015 in SPACE -> no ARVALID. Drop to 1008 -> ARVALID within 1 cycle.
- LOOP=1, DATASIZE=20 -> after the 20th word the next ARADDR=BASEADDR with ARLEN=15, continuing indefinitely.
- COMMAND=10 mid-burst -> the burst completes (16 writes), PAUSE, no ARVALID. Then COMMAND=01 -> next ARADDR = BASEADDR+0x40. Then COMMAND=11 -> IDLE and the next start begins at BASEADDR.
- RRESP=10 on beat 3 -> RDERR=1 and stays set after the burst. ARST asserted mid-DATA -> all outputs 0 asynchronously.
- With SND_MEMRD_4K_EN defined: BASEADDR=0x1000_0FF0, DATASIZE=16 -> ARLEN=3 at 0x1000_0FF0, then ARLEN=11 at 0x1000_1000.

Source files
------------

// File: rtl/snd_memreader.sv
// Sound sample fetcher: AXI4 read bursts from DDR into the sample FIFO.
// Optional SND_MEMRD_4K_EN splits bursts at 4 KB boundaries.
module snd_memreader #(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic [1:0]  COMMAND,
  input  logic        LOOP,
  input  logic [31:0] BASEADDR,
  input  logic [28:0] DATASIZE,
  input  logic [10:0] FIFOWRCNT,
  output logic        FIFOWR,
  output logic [31:0] FIFODIN,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic        BUSY,
  output logic        RDERR
);

  localparam logic [8:0]  BL = 9'(BURST_LEN);
  localparam logic [11:0] FD = 12'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPACE,
    S_ADDR,
    S_DATA,
    S_SET1,
    S_SET2,
    S_PAUSE
  } state_t;

  state_t      state_q, state_d;
  logic [28:0] wcnt_q, wcnt_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic        rderr_q, rderr_d;
  logic        pstop_q, pstop_d;
  logic        ppause_q, ppause_d;
  logic        fifowr_q, fifowr_d;
  logic [31:0] fifodin_q, fifodin_d;

  logic        cmd_play;
  logic        cmd_pause;
  logic        cmd_stop;
  logic        eod;
  logic [28:0] rem;
  logic [31:0] nxt_addr;
  logic [8:0]  len_c;
  logic [11:0] free;
  logic        fifo_ok;

  assign cmd_play  = (COMMAND == 2'b01);
  assign cmd_pause = (COMMAND == 2'b10);
  assign cmd_stop  = (COMMAND == 2'b11);

  // WORDCNT past DATASIZE (size shrunk mid-play) counts as end-of-data
  assign eod      = (wcnt_q >= DATASIZE);
  assign rem      = eod ? '0 : DATASIZE - wcnt_q;
  assign nxt_addr = BASEADDR + {1'b0, wcnt_q, 2'b00};

`ifdef SND_MEMRD_4K_EN
  logic [12:0] room;
  logic [10:0] lim;
  assign room = 13'd4096 - {1'b0, nxt_addr[11:0]};
  assign lim  = room[12:2];
`endif

  always_comb begin
    len_c = BL;
    if (rem < 29'(BURST_LEN))
      len_c = rem[8:0];
`ifdef SND_MEMRD_4K_EN
    if ({2'b00, len_c} > lim)
      len_c = lim[8:0];
`endif
  end

  assign free    = FD - {1'b0, FIFOWRCNT};
  assign fifo_ok = ({1'b0, FIFOWRCNT} <= FD) &&
                   (free >= {3'b000, len_c});

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      rderr_q   <= 1'b0;
      pstop_q   <= 1'b0;
      ppause_q  <= 1'b0;
      fifowr_q  <= 1'b0;
      fifodin_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      rderr_q   <= rderr_d;
      pstop_q   <= pstop_d;
      ppause_q  <= ppause_d;
      fifowr_q  <= fifowr_d;
      fifodin_q <= fifodin_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    rderr_d   = rderr_q;
    pstop_d   = pstop_q;
    ppause_d  = ppause_q;
    fifowr_d  = 1'b0;
    fifodin_d = fifodin_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_play && DATASIZE != '0) begin
          state_d = S_SPACE;
          rderr_d = 1'b0;
        end
      end
      S_SPACE: begin
        if (cmd_stop) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else if (cmd_pause) begin
          state_d = S_PAUSE;
        end else if (eod) begin
          wcnt_d = '0;
          if (!LOOP)
            state_d = S_IDLE;
        end else if (fifo_ok) begin
          state_d  = S_ADDR;
          araddr_d = nxt_addr;
          arlen_d  = 8'(len_c - 9'd1);
        end
      end
      S_ADDR: begin
        if (ARREADY)
          state_d = S_DATA;
      end
      S_DATA: begin
        if (cmd_stop)
          pstop_d = 1'b1;
        if (cmd_pause)
          ppause_d = 1'b1;
        if (RVALID) begin
          fifowr_d  = 1'b1;
          fifodin_d = RDATA;
          wcnt_d    = wcnt_q + 29'd1;
          if (RRESP != 2'b00)
            rderr_d = 1'b1;
          if (RLAST)
            state_d = S_SET1;
        end
      end
      S_SET1: begin
        state_d = S_SET2;
      end
      // second settle cycle: FIFOWRCNT now includes the last write
      S_SET2: begin
        pstop_d  = 1'b0;
        ppause_d = 1'b0;
        if (pstop_q) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else if (ppause_q) begin
          state_d = S_PAUSE;
        end else if (eod) begin
          wcnt_d  = '0;
          state_d = LOOP ? S_SPACE : S_IDLE;
        end else begin
          state_d = S_SPACE;
        end
      end
      S_PAUSE: begin
        if (cmd_play) begin
          state_d = S_SPACE;
        end else if (cmd_stop) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ARVALID = (state_q == S_ADDR);
  assign RREADY  = (state_q == S_DATA);
  assign BUSY    = (state_q != S_IDLE);
  assign ARADDR  = araddr_q;
  assign ARLEN   = arlen_q;
  assign RDERR   = rderr_q;
  assign FIFOWR  = fifowr_q;
  assign FIFODIN = fifodin_q;

endmodule

// File: tb/tb_snd_memreader.sv
// Bench for snd_memreader: AXI slave model, word-stream model,
// per-cycle compare at negedge plus directed literal checks.
module tb_snd_memreader;
  localparam int BL = 16;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b1;
  logic [1:0]  COMMAND = '0;
  logic        LOOP = 1'b0;
  logic [31:0] BASEADDR = '0;
  logic [28:0] DATASIZE = '0;
  logic [10:0] FIFOWRCNT = '0;
  logic        FIFOWR;
  logic [31:0] FIFODIN;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0;
  logic        RLAST = 1'b0;
  logic        RVALID = 1'b0;
  logic        RREADY;
  logic        BUSY;
  logic        RDERR;

  snd_memreader #(.BURST_LEN(BL), .FIFO_DEPTH(1024)) dut (
    .ACLK(ACLK), .ARST(ARST), .COMMAND(COMMAND), .LOOP(LOOP),
    .BASEADDR(BASEADDR), .DATASIZE(DATASIZE),
    .FIFOWRCNT(FIFOWRCNT), .FIFOWR(FIFOWR), .FIFODIN(FIFODIN),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .BUSY(BUSY), .RDERR(RDERR)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_base = '0;
  int          m_size = 0;
  int          m_w = 0;
  bit          m_rderr = 1'b0;
  int          wr_cnt = 0;
  int          beats_left = 0;
  int          beat_no = 0;
  int          err_beat = 0;
  logic [31:0] cur_addr = '0;
  bit          stray = 1'b0;
  int          cyc = 0;
  bit          p_arvalid = 1'b0;
  bit          p_rready = 1'b0;
  logic [31:0] p_araddr = '0;
  logic [7:0]  p_arlen = '0;
  logic [39:0] blog[$];

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int widx();
    return (m_size == 0) ? 0 : (m_w % m_size);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_base + 32'(4 * widx());
  endfunction

  function automatic int exp_len();
    int rem;
    int l;
    logic [31:0] a;
    a   = exp_addr();
    rem = m_size - widx();
    l   = (rem < BL) ? rem : BL;
`ifdef SND_MEMRD_4K_EN
    begin
      int lim;
      lim = (4096 - int'(a[11:0])) / 4;
      if (lim < l) l = lim;
    end
`endif
    return l;
  endfunction

  // one clock: judge last edge's handshakes, check outputs, drive slave
  task automatic step();
    bit ar_hs;
    bit r_hs;
    logic [31:0] ea;
    @(negedge ACLK);
    cyc++;
    ar_hs = p_arvalid && ARREADY;
    r_hs  = p_rready && RVALID;
    if (r_hs) begin
      if (RRESP != 2'b00) m_rderr = 1'b1;
      ea = exp_addr();
      chk("fifowr", FIFOWR, 1);
      chk("fifodin", FIFODIN, mem(ea));
      m_w++;
      wr_cnt++;
      if (beats_left > 0) beats_left--;
      cur_addr += 4;
      beat_no++;
    end else begin
      chk("fifowr_quiet", FIFOWR, 0);
    end
    if (ar_hs) begin
      chk("araddr", p_araddr, exp_addr());
      chk("arlen", p_arlen, exp_len() - 1);
      blog.push_back({p_araddr, p_arlen});
      beats_left = int'(p_arlen) + 1;
      cur_addr   = p_araddr;
      beat_no    = 1;
    end else if (p_arvalid) begin
      chk("arvalid_hold", ARVALID, 1);
      chk("araddr_hold", ARADDR, p_araddr);
      chk("arlen_hold", ARLEN, p_arlen);
    end
    chk("rready", RREADY, beats_left > 0);
    if (beats_left > 0) begin
      chk("ar_single", ARVALID, 0);
      chk("busy_data", BUSY, 1);
    end
    chk("rderr", RDERR, m_rderr);
    ARREADY = ARVALID && (cyc % 3 != 0);
    if (beats_left > 0 && cyc % 4 != 2) begin
      RVALID = 1'b1;
      RDATA  = mem(cur_addr);
      RLAST  = (beats_left == 1);
      RRESP  = (beat_no == err_beat) ? 2'b10 : 2'b00;
    end else if (stray) begin
      RVALID = 1'b1;
      RDATA  = 32'hDEAD_BEEF;
      RLAST  = 1'b1;
      RRESP  = 2'b10;
    end else begin
      RVALID = 1'b0;
      RDATA  = '0;
      RLAST  = 1'b0;
      RRESP  = 2'b00;
    end
    p_arvalid = ARVALID;
    p_rready  = RREADY;
    p_araddr  = ARADDR;
    p_arlen   = ARLEN;
  endtask

  task automatic setup(logic [31:0] b, int sz, bit lp);
    BASEADDR = b;
    DATASIZE = 29'(sz);
    LOOP     = lp;
    m_base   = b;
    m_size   = sz;
    m_w      = 0;
    blog.delete();
  endtask

  task automatic play();
    if (!BUSY && DATASIZE != '0) m_rderr = 1'b0;
    COMMAND = 2'b01;
    step();
    COMMAND = 2'b00;
  endtask

  task automatic wait_idle(int maxc);
    int i = 0;
    do begin
      step();
      i++;
    end while (BUSY && i < maxc);
    chk("idle_wait", BUSY, 0);
  endtask

  task automatic wait_wr(int n, int maxc);
    int i = 0;
    while (wr_cnt < n && i < maxc) begin
      step();
      i++;
    end
    chk("wr_wait", wr_cnt >= n, 1);
  endtask

  task automatic wait_log(int n, int maxc);
    int i = 0;
    while (blog.size() < n && i < maxc) begin
      step();
      i++;
    end
    chk("log_wait", blog.size() >= n, 1);
  endtask

  task automatic stop_idle();
    int i = 0;
    COMMAND = 2'b11;
    do begin
      step();
      i++;
    end while (BUSY && i < 300);
    COMMAND = 2'b00;
    chk("stop_idle", BUSY, 0);
    m_w = 0;
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_fifowr"}, FIFOWR, 0);
    chk({nm, "_fifodin"}, FIFODIN, 0);
    chk({nm, "_araddr"}, ARADDR, 0);
    chk({nm, "_arlen"}, ARLEN, 0);
    chk({nm, "_arvalid"}, ARVALID, 0);
    chk({nm, "_rready"}, RREADY, 0);
    chk({nm, "_busy"}, BUSY, 0);
    chk({nm, "_rderr"}, RDERR, 0);
  endtask

  initial begin
    int w0;
    repeat (3) step();
    ARST = 1'b0;
    step();
    chk_zero("reset");

    // zero-length start is refused
    setup(32'h0800_0000, 0, 1'b0);
    play();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("zero_busy", BUSY, 0);
      chk("zero_arvalid", ARVALID, 0);
    end

    // stray read data while idle is ignored
    stray = 1'b1;
    repeat (5) step();
    stray = 1'b0;
    step();

    // three bursts 16/16/8
    setup(32'h1000_0000, 40, 1'b0);
    w0 = wr_cnt;
    play();
    wait_idle(1000);
    chk("t1_nbursts", blog.size(), 3);
    chk("t1_b0", blog[0], {32'h1000_0000, 8'd15});
    chk("t1_b1", blog[1], {32'h1000_0040, 8'd15});
    chk("t1_b2", blog[2], {32'h1000_0080, 8'd7});
    chk("t1_writes", wr_cnt - w0, 40);

    // FIFO fill gating
    setup(32'h2000_0000, 16, 1'b0);
    FIFOWRCNT = 11'd1015;
    play();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("full_arvalid", ARVALID, 0);
      chk("full_busy", BUSY, 1);
    end
    FIFOWRCNT = 11'd1008;
    step();
    chk("room_arvalid", ARVALID, 1);
    FIFOWRCNT = 11'd0;
    wait_idle(300);

    // looping playback
    setup(32'h3000_0000, 20, 1'b1);
    w0 = wr_cnt;
    play();
    wait_wr(w0 + 60, 2000);
    chk("loop_b1", blog[1], {32'h3000_0040, 8'd3});
    chk("loop_b2", blog[2], {32'h3000_0000, 8'd15});
    chk("loop_busy", BUSY, 1);
    stop_idle();

    // pause mid-burst, resume, stop, restart
    setup(32'h4000_0000, 48, 1'b0);
    w0 = wr_cnt;
    play();
    wait_wr(w0 + 1, 200);
    COMMAND = 2'b10;
    step();
    COMMAND = 2'b00;
    wait_wr(w0 + 16, 200);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pause_arvalid", ARVALID, 0);
      chk("pause_busy", BUSY, 1);
    end
    chk("pause_nbursts", blog.size(), 1);
    chk("pause_writes", wr_cnt - w0, 16);
    play();
    wait_log(2, 200);
    chk("resume_addr", blog[1][39:8], 32'h4000_0040);
    stop_idle();
    blog.delete();
    play();
    wait_log(1, 200);
    chk("restart_addr", blog[0][39:8], 32'h4000_0000);
    stop_idle();

    // read error is sticky and cleared on restart
    setup(32'h5000_0000, 16, 1'b0);
    err_beat = 3;
    play();
    wait_idle(300);
    chk("err_sticky", RDERR, 1);
    err_beat = 0;
    setup(32'h5000_0000, 16, 1'b0);
    play();
    chk("err_clear", RDERR, 0);
    wait_idle(300);

    // asynchronous reset mid-burst
    setup(32'h6000_0000, 32, 1'b0);
    err_beat = 1;
    w0 = wr_cnt;
    play();
    wait_wr(w0 + 2, 200);
    chk("pre_rst_err", RDERR, 1);
    chk("pre_rst_rready", RREADY, 1);
    #2;
    ARST = 1'b1;
    #1;
    chk_zero("arst");
    err_beat   = 0;
    beats_left = 0;
    m_rderr    = 1'b0;
    p_arvalid  = 1'b0;
    p_rready   = 1'b0;
    p_araddr   = '0;
    p_arlen    = '0;
    RVALID     = 1'b0;
    RLAST      = 1'b0;
    RRESP      = 2'b00;
    ARREADY    = 1'b0;
    repeat (2) step();
    ARST = 1'b0;
    repeat (3) step();
    chk("post_rst_busy", BUSY, 0);

`ifdef SND_MEMRD_4K_EN
    setup(32'h1000_0FF0, 16, 1'b0);
    play();
    wait_idle(300);
    chk("k4_nbursts", blog.size(), 2);
    chk("k4_b0", blog[0], {32'h1000_0FF0, 8'd3});
    chk("k4_b1", blog[1], {32'h1000_1000, 8'd11});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
